// File: rtl/halflife_timer_p.sv
// halflife_timer_p: a prescaled counter that counts up, counts down or halves a
// quantity. It runs while en is high and stops in a terminal state that only load
// or rst can clear.
// Ports: clk/rst (sync, active high); en, mode, load, load_val and period are
// controls. value and halvings are registered state. zero and busy are decoded
// from the registers. done is a one-cycle registered pulse when the count reaches
// its terminal condition.
module halflife_timer_p #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 16,
  parameter int HALV_W  = 4,
  parameter int WRAP    = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [PRESC_W-1:0] period,
  output logic [WIDTH-1:0]   value,
  output logic [HALV_W-1:0]  halvings,
  output logic               zero,
  output logic               done,
  output logic               busy
);

  localparam logic [WIDTH-1:0]   VMAX  = '1;
  localparam logic [HALV_W-1:0]  HMAX  = '1;
  localparam logic [WIDTH-1:0]   ONE_V = 1;
  localparam logic [HALV_W-1:0]  ONE_H = 1;
  localparam logic [PRESC_W-1:0] ONE_P = 1;

  logic [PRESC_W-1:0] pres_cnt;
  logic               terminal;
  logic               tick;
  logic [WIDTH-1:0]   value_nxt;
  logic [HALV_W-1:0]  halv_nxt;
  logic               term_hit;
  logic               done_hit;

  // The >= compare means that lowering period below the running count fires on
  // the next enabled cycle. The prescaler therefore never wraps through its full range.
  assign tick = en && !terminal && (pres_cnt >= period);

  // Compute the state that a tick in the current mode would commit.
  always_comb begin
    value_nxt = value;
    halv_nxt  = halvings;
    term_hit  = 1'b0;
    done_hit  = 1'b0;
    case (mode)
      2'b01: begin
        if (WRAP != 0) begin
          // The wrap to zero is reported but the count keeps going.
          value_nxt = value + ONE_V;
          done_hit  = (value == VMAX);
        end else begin
          if (value != VMAX) value_nxt = value + ONE_V;
          term_hit = (value_nxt == VMAX);
          done_hit = term_hit;
        end
      end
      2'b10: begin
        if (value != '0) value_nxt = value - ONE_V;
        term_hit = (value_nxt == '0);
        done_hit = term_hit;
      end
      2'b11: begin
        value_nxt = value >> 1;
        // The step that empties the quantity (1 -> 0, or 0 -> 0) is not
        // counted as an elapsed half-life.
        if ((value_nxt != '0) && (halvings != HMAX)) halv_nxt = halvings + ONE_H;
        term_hit = (value_nxt == '0);
        done_hit = term_hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value    <= '0;
      halvings <= '0;
      pres_cnt <= '0;
      done     <= 1'b0;
      terminal <= 1'b0;
    end else if (load) begin
      // Load wins over a coincident tick. That tick is dropped.
      value    <= load_val;
      halvings <= '0;
      pres_cnt <= '0;
      done     <= 1'b0;
      terminal <= 1'b0;
    end else begin
      done <= 1'b0;
      if (en && !terminal) pres_cnt <= tick ? '0 : pres_cnt + ONE_P;
      if (tick) begin
        value    <= value_nxt;
        halvings <= halv_nxt;
        done     <= done_hit;
        if (term_hit) terminal <= 1'b1;
      end
    end
  end

  assign zero = (value == '0);
  assign busy = en && (mode != 2'b00) && !terminal;

endmodule

// File: tb/tb_halflife_timer_p.sv
// Bench for halflife_timer_p. The bench drives two instances with identical
// stimulus: defaults (saturating, 4-bit halvings) and a wrapping instance with
// 2-bit halvings. It compares both against behavioural models and literal expectations.
module tb_halflife_timer_p;

  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [1:0]  mode;
  logic [7:0]  load_val;
  logic [15:0] period;

  logic [7:0]  v0, v1;
  logic [3:0]  h0;
  logic [1:0]  h1;
  logic        z0, z1, d0, d1, b0, b1;

  int tests  = 0;
  int fails  = 0;
  int dc0    = 0;
  int dc1    = 0;
  bit chk_on = 1'b0;

  // Model state per instance: value, halvings, prescaler, terminal, done.
  int mv [2];
  int mh [2];
  int mp [2];
  bit mt [2];
  bit md [2];
  int hmax [2] = '{15, 3};
  bit wrp  [2] = '{1'b0, 1'b1};

  always #5 clk = ~clk;

  halflife_timer_p #(.WIDTH(8), .PRESC_W(16), .HALV_W(4), .WRAP(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .period(period), .value(v0), .halvings(h0), .zero(z0), .done(d0), .busy(b0));

  halflife_timer_p #(.WIDTH(8), .PRESC_W(16), .HALV_W(2), .WRAP(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .period(period), .value(v1), .halvings(h1), .zero(z1), .done(d1), .busy(b1));

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // The behavioural model updates once per clock edge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int v, h, p;
      bit t, d, tk;
      v = mv[i]; h = mh[i]; p = mp[i]; t = mt[i]; d = 1'b0;
      if (rst) begin
        v = 0; h = 0; p = 0; t = 1'b0;
      end else if (load) begin
        v = int'(load_val); h = 0; p = 0; t = 1'b0;
      end else if (en && !t) begin
        tk = (p >= int'(period));
        p  = tk ? 0 : p + 1;
        if (tk) begin
          case (mode)
            2'd1: begin
              if (wrp[i]) begin
                v = (v + 1) % 256;
                if (v == 0) d = 1'b1;
              end else begin
                if (v < 255) v = v + 1;
                if (v == 255) begin t = 1'b1; d = 1'b1; end
              end
            end
            2'd2: begin
              if (v > 0) v = v - 1;
              if (v == 0) begin t = 1'b1; d = 1'b1; end
            end
            2'd3: begin
              if (v >= 2 && h < hmax[i]) h = h + 1;
              v = v / 2;
              if (v == 0) begin t = 1'b1; d = 1'b1; end
            end
            default: ;
          endcase
        end
      end
      mv[i] <= v; mh[i] <= h; mp[i] <= p; mt[i] <= t; md[i] <= d;
    end
  end

  // On each cycle, compare both instances against the model.
  always @(negedge clk) begin
    if (d0) dc0 <= dc0 + 1;
    if (d1) dc1 <= dc1 + 1;
    if (chk_on) begin
      chk("value0", int'(v0), mv[0]);
      chk("halv0",  int'(h0), mh[0]);
      chk("zero0",  int'(z0), int'(mv[0] == 0));
      chk("done0",  int'(d0), int'(md[0]));
      chk("busy0",  int'(b0), int'(en && mode != 2'd0 && !mt[0]));
      chk("value1", int'(v1), mv[1]);
      chk("halv1",  int'(h1), mh[1]);
      chk("zero1",  int'(z1), int'(mv[1] == 0));
      chk("done1",  int'(d1), int'(md[1]));
      chk("busy1",  int'(b1), int'(en && mode != 2'd0 && !mt[1]));
    end
  end

  // Wait for n rising edges, then return just after the last one.
  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int lv, input int md_i, input int per);
    load = 1'b1; load_val = 8'(lv); mode = 2'(md_i); period = 16'(per); en = 1'b1;
    clk_n(1);
    load = 1'b0;
  endtask

  int base0, base1;
  int decay_exp [8] = '{100, 50, 25, 12, 6, 3, 1, 0};
  int h1_exp    [8] = '{1, 2, 3, 3, 3, 3, 3, 3};

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; mode = 2'd0; load_val = 8'd0; period = 16'd0;
    clk_n(2);
    chk("rst_value", int'(v0), 0);
    chk("rst_zero",  int'(z0), 1);
    chk("rst_done",  int'(d0), 0);
    rst = 1'b0;
    chk_on = 1'b1;

    // Decay from 200 with a period of 3: one halving every 4 cycles.
    base0 = dc0;
    do_load(200, 3, 3);
    chk("decay_load", int'(v0), 200);
    for (int k = 0; k < 8; k++) begin
      clk_n(4);
      chk("decay_step", int'(v0), decay_exp[k]);
    end
    chk("decay_done_now", int'(d0), 1);
    clk_n(6);
    chk("decay_halv", int'(h0), 7);
    chk("decay_busy", int'(b0), 0);
    chk("decay_done_cnt", dc0 - base0, 1);

    // Up count from 254 with period 0.
    do_load(254, 1, 0);
    clk_n(1);
    chk("up_sat_255", int'(v0), 255);
    chk("up_sat_done", int'(d0), 1);
    chk("up_wrap_255", int'(v1), 255);
    clk_n(1);
    chk("up_sat_hold", int'(v0), 255);
    chk("up_wrap_0", int'(v1), 0);
    chk("up_wrap_done", int'(d1), 1);
    clk_n(2);
    chk("up_wrap_2", int'(v1), 2);
    chk("up_sat_busy", int'(b0), 0);

    // Count down while en toggles every 3 cycles.
    base0 = dc0;
    do_load(3, 2, 1);
    for (int c = 0; c < 24; c++) begin
      en = ((c / 3) % 2) == 0;
      clk_n(1);
    end
    chk("down_en_value", int'(v0), 0);
    chk("down_en_done", dc0 - base0, 1);

    // A load that coincides with a tick takes priority over the tick.
    do_load(50, 2, 0);
    chk("load_vs_tick", int'(v0), 50);
    clk_n(1);
    chk("after_load_tick", int'(v0), 49);

    // Reduce period below the running prescaler count.
    do_load(100, 2, 10);
    clk_n(7);
    chk("period_pre", int'(v0), 100);
    period = 16'd2;
    clk_n(1);
    chk("period_cut", int'(v0), 99);

    // Assert reset mid-decay together with a load.
    do_load(128, 3, 0);
    clk_n(2);
    chk("rst_mid_pre", int'(v0), 32);
    rst = 1'b1; load = 1'b1; load_val = 8'd77;
    clk_n(1);
    rst = 1'b0; load = 1'b0;
    chk("rst_mid_value", int'(v0), 0);
    chk("rst_mid_halv",  int'(h0), 0);
    chk("rst_mid_done",  int'(d0), 0);
    chk("rst_mid_zero",  int'(z0), 1);

    // Halving counter saturates on the 2-bit instance.
    do_load(255, 3, 0);
    for (int k = 0; k < 8; k++) begin
      clk_n(1);
      chk("hsat_halv", int'(h1), h1_exp[k]);
    end
    chk("hsat_value", int'(v1), 0);

    // Randomized run.
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(63) == 0);
      load = ($urandom_range(15) == 0);
      case ($urandom_range(4))
        0:       load_val = 8'd0;
        1:       load_val = 8'd254;
        2:       load_val = 8'd1;
        default: load_val = 8'($urandom_range(255));
      endcase
      en = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(31) == 0) period = 16'($urandom_range(5));
      clk_n(1);
    end
    rst = 1'b0; load = 1'b0;
    clk_n(2);
    chk_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
